seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (legal range 4..64).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only while busy=0.
REQ-005 dividend  input  WIDTH  numerator, sampled with start.
REQ-006 divisor  input  WIDTH  denominator, sampled with start.
REQ-007 signed_op  input  1  1 = two's-complement division; present only when DIV_SIGNED_EN is defined.
REQ-008 busy  output  1  high while an operation is in flight.
REQ-009 out_valid  output  1  one-cycle pulse marking valid results.
REQ-010 quotient  output  WIDTH  result quotient.
REQ-011 remainder  output  WIDTH  result remainder.
REQ-012 div_by_zero  output  1  set with out_valid when the sampled divisor was 0.

Function
REQ-013 The FSM SHALL have states IDLE, CALC and DONE; reset state is IDLE.
REQ-014 IDLE: start=1 at an edge SHALL latch operands, clear a log2(WIDTH)+1-bit iteration counter, and move to CALC (or to DONE if divisor=0).
REQ-015 CALC: each edge SHALL perform one restoring step: shift {rem,quo} left by 1, trial-subtract divisor from the upper part, keep the difference and shift in 1 if rem>=divisor, else keep rem and shift in 0.
REQ-016 CALC SHALL execute exactly WIDTH steps, then enter DONE.
REQ-017 DONE SHALL last one cycle with out_valid=1, then return to IDLE.
REQ-018 Latency: out_valid SHALL be high in the cycle following edge k+WIDTH+1, where edge k sampled start (divisor nonzero).
REQ-019 Divisor=0: out_valid after edge k+1; quotient = all ones, remainder = dividend, div_by_zero=1.
REQ-020 busy SHALL be 1 in CALC and DONE, 0 in IDLE.
REQ-021 start while busy=1 SHALL be ignored; it is not queued.
REQ-022 start in the same cycle as out_valid SHALL be ignored; a new request is accepted from the next IDLE cycle.
REQ-023 quotient, remainder, div_by_zero SHALL hold their last values until the next result is written; div_by_zero clears when a nonzero-divisor result is written.
REQ-024 Operands changing during CALC SHALL not affect the result.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, busy=0, out_valid=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
REQ-026 rst during CALC or DONE SHALL abort the operation with no out_valid pulse; rst has priority over start.

Configuration
REQ-027 Macro DIV_SIGNED_EN: when defined, signed_op port exists; when undefined, port absent and all division unsigned.
REQ-028 With DIV_SIGNED_EN and signed_op=1 at start: operands SHALL be converted to magnitudes, the unsigned core run, quotient negated if operand signs differ, remainder taking the dividend's sign; latency unchanged.
REQ-029 Signed overflow (MIN / -1) SHALL return quotient=MIN, remainder=0, div_by_zero=0.
REQ-030 Signed divide-by-zero SHALL return quotient=all ones, remainder=dividend, div_by_zero=1.

Verification (WIDTH=32)
REQ-031 start, 100 / 7 -> out_valid 33 edges later, quotient=14, remainder=2, div_by_zero=0.
REQ-032 start, 5 / 0 -> out_valid after 1 edge, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
REQ-033 0xFFFFFFFF / 1, then start pulsed at cycle 10 while busy -> single result quotient=0xFFFFFFFF, remainder=0; second start ignored.
REQ-034 start 1000 / 3, rst at cycle 15 -> no out_valid, all outputs 0, next request 9 / 3 yields quotient=3, remainder=0.
REQ-035 DIV_SIGNED_EN, signed_op=1, -7 / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider (one quotient bit per clock).
// Flow: IDLE -> CALC (WIDTH steps) -> DONE -> IDLE. A zero divisor
// skips CALC and goes straight to DONE.
// out_valid is a one-cycle pulse on the clock after DONE. The result
// registers hold their value until the next result is written.
// Optional macro DIV_SIGNED_EN adds a signed_op input for two's-complement
// division. Signed division runs the unsigned core on magnitudes and then
// fixes the signs of the results.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   rem_reg;
  logic [WIDTH-1:0]   quo_reg;
  logic [WIDTH-1:0]   dvs_reg;
  logic               neg_quo_reg;
  logic               neg_rem_reg;
  logic               dz_reg;
  logic               busy_reg;
  logic               out_valid_reg;
  logic [WIDTH-1:0]   quotient_reg;
  logic [WIDTH-1:0]   remainder_reg;
  logic               div_by_zero_reg;

  logic               op_signed;
  logic               dividend_neg;
  logic               divisor_neg;
  logic [WIDTH-1:0]   dividend_mag;
  logic [WIDTH-1:0]   divisor_mag;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   quo_final;
  logic [WIDTH-1:0]   rem_final;

`ifdef DIV_SIGNED_EN
  assign op_signed = signed_op;
`else
  assign op_signed = 1'b0;
`endif

  // Operand magnitudes for the unsigned core. Negating MIN gives MIN,
  // which is still the correct unsigned magnitude.
  always_comb begin
    dividend_neg = op_signed & dividend[WIDTH-1];
    divisor_neg  = op_signed & divisor[WIDTH-1];
    dividend_mag = dividend_neg ? (~dividend + 1'b1) : dividend;
    divisor_mag  = divisor_neg  ? (~divisor  + 1'b1) : divisor;
  end

  // One restoring step. Shift {rem, quo} left by one bit, then
  // trial-subtract the divisor. When there is no borrow, the partial
  // remainder was >= divisor: keep the difference and shift in a 1.
  always_comb begin
    trial    = {rem_reg, quo_reg[WIDTH-1]};
    diff     = trial - {1'b0, dvs_reg};
    rem_next = trial[WIDTH-1:0];
    quo_next = {quo_reg[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH]) begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo_reg[WIDTH-2:0], 1'b1};
    end
  end

  // Sign correction applied when the result is committed.
  always_comb begin
    quo_final = neg_quo_reg ? (~quo_reg + 1'b1) : quo_reg;
    rem_final = neg_rem_reg ? (~rem_reg + 1'b1) : rem_reg;
  end

  // Control FSM and datapath registers. All outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      rem_reg         <= '0;
      quo_reg         <= '0;
      dvs_reg         <= '0;
      neg_quo_reg     <= 1'b0;
      neg_rem_reg     <= 1'b0;
      dz_reg          <= 1'b0;
      busy_reg        <= 1'b0;
      out_valid_reg   <= 1'b0;
      quotient_reg    <= '0;
      remainder_reg   <= '0;
      div_by_zero_reg <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // The cycle that shows out_valid is IDLE but does not accept start.
          if (start && !out_valid_reg) begin
            cnt_reg  <= '0;
            busy_reg <= 1'b1;
            dvs_reg  <= divisor_mag;
            if (divisor == '0) begin
              rem_reg     <= dividend;
              quo_reg     <= '1;
              dz_reg      <= 1'b1;
              neg_quo_reg <= 1'b0;
              neg_rem_reg <= 1'b0;
              state_reg   <= DONE;
            end else begin
              rem_reg     <= '0;
              quo_reg     <= dividend_mag;
              dz_reg      <= 1'b0;
              neg_quo_reg <= dividend_neg ^ divisor_neg;
              neg_rem_reg <= dividend_neg;
              state_reg   <= CALC;
            end
          end
        end
        CALC: begin
          rem_reg <= rem_next;
          quo_reg <= quo_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_STEP) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          out_valid_reg   <= 1'b1;
          quotient_reg    <= quo_final;
          remainder_reg   <= rem_final;
          div_by_zero_reg <= dz_reg;
          busy_reg        <= 1'b0;
          state_reg       <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_reg;
  assign out_valid   = out_valid_reg;
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: compares seq_divider against an arithmetic reference model.
// The model predicts acceptance, result timing and values. A negedge
// process checks every DUT output on every cycle. Directed cases pin
// exact literal values.
module tb_seq_divider;
  localparam int W = 32;
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ALL_ONES = '1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         signed_op = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         out_valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
`ifdef DIV_SIGNED_EN
    .signed_op(signed_op),
`endif
    .busy(busy),
    .out_valid(out_valid),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference division. Returns {div_by_zero, quotient, remainder}.
  function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    logic [W-1:0] q;
    logic [W-1:0] r;
    sa = a;
    sb = b;
    if (b == '0)
      return {1'b1, ALL_ONES, a};
    if (s) begin
      if (a == MIN_VAL && b == ALL_ONES)
        return {1'b0, MIN_VAL, {W{1'b0}}};
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {1'b0, q, r};
  endfunction

  // Model state: one request in flight, finishing at a known edge number.
  logic         m_pending = 1'b0;
  int           m_done_edge = 0;
  logic [2*W:0] m_pres = '0;
  logic         m_valid = 1'b0;
  logic [W-1:0] m_q = '0;
  logic [W-1:0] m_r = '0;
  logic         m_dz = 1'b0;
  logic         eff_signed;

`ifdef DIV_SIGNED_EN
  assign eff_signed = signed_op;
`else
  assign eff_signed = 1'b0;
`endif

  // Model update: predict what each clock edge does.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    m_valid <= 1'b0;
    if (rst) begin
      m_pending <= 1'b0;
      m_q <= '0;
      m_r <= '0;
      m_dz <= 1'b0;
    end else if (m_pending) begin
      if (cyc + 1 == m_done_edge) begin
        m_valid <= 1'b1;
        m_q <= m_pres[2*W-1:W];
        m_r <= m_pres[W-1:0];
        m_dz <= m_pres[2*W];
        m_pending <= 1'b0;
      end
    end else if (start && !m_valid) begin
      m_pending <= 1'b1;
      m_done_edge <= cyc + 1 + ((divisor == '0) ? 1 : W + 1);
      m_pres <= ref_div(dividend, divisor, eff_signed);
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (cyc > 0) begin
      check("busy", 64'(busy), 64'(m_pending));
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("quotient", 64'(quotient), 64'(m_q));
      check("remainder", 64'(remainder), 64'(m_r));
      check("div_by_zero", 64'(div_by_zero), 64'(m_dz));
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    dividend = a;
    divisor = b;
    signed_op = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges after the sampling edge until out_valid, bounded.
  task automatic wait_result(output int lat);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("result_timeout", 64'(n), 64'(0));
    lat = n;
  endtask

  task automatic count_pulses(input int ncyc, output int pulses);
    pulses = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
  endtask

  initial begin
    int lat;
    int pulses;
    logic [2*W:0] pin;

    // Pin the reference model itself on hand-computed cases.
    pin = ref_div(32'd100, 32'd7, 1'b0);
    check("model_100_7_q", 64'(pin[2*W-1:W]), 64'd14);
    check("model_100_7_r", 64'(pin[W-1:0]), 64'd2);
    pin = ref_div(32'hFFFF_FFF9, 32'd2, 1'b1);
    check("model_m7_2_q", 64'(pin[2*W-1:W]), 64'hFFFF_FFFD);
    check("model_m7_2_r", 64'(pin[W-1:0]), 64'hFFFF_FFFF);

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_quotient", 64'(quotient), 64'd0);
    check("rst_remainder", 64'(remainder), 64'd0);
    check("rst_dz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 100 / 7
    issue(32'd100, 32'd7, 1'b0);
    wait_result(lat);
    $display("op 100/7: latency=%0d q=%0d r=%0d dz=%0d", lat, quotient, remainder, div_by_zero);
    check("lat_100_7", 64'(lat), 64'd33);
    check("q_100_7", 64'(quotient), 64'd14);
    check("r_100_7", 64'(remainder), 64'd2);
    check("dz_100_7", 64'(div_by_zero), 64'd0);
    @(negedge clk);

    // 5 / 0
    issue(32'd5, 32'd0, 1'b0);
    wait_result(lat);
    $display("op 5/0: latency=%0d q=0x%0h r=%0d dz=%0d", lat, quotient, remainder, div_by_zero);
    check("lat_5_0", 64'(lat), 64'd1);
    check("q_5_0", 64'(quotient), 64'hFFFF_FFFF);
    check("r_5_0", 64'(remainder), 64'd5);
    check("dz_5_0", 64'(div_by_zero), 64'd1);
    @(negedge clk);

    // 0xFFFFFFFF / 1 with a second start pulsed while busy.
    issue(32'hFFFF_FFFF, 32'd1, 1'b0);
    repeat (8) @(negedge clk);
    check("busy_mid", 64'(busy), 64'd1);
    dividend = 32'd3;
    divisor = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_result(lat);
    $display("op FFFFFFFF/1: q=0x%0h r=%0d", quotient, remainder);
    check("q_ones_1", 64'(quotient), 64'hFFFF_FFFF);
    check("r_ones_1", 64'(remainder), 64'd0);
    count_pulses(60, pulses);
    check("ignored_start_pulses", 64'(pulses), 64'd0);

    // 1000 / 3 aborted by reset.
    issue(32'd1000, 32'd3, 1'b0);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_q", 64'(quotient), 64'd0);
    check("abort_r", 64'(remainder), 64'd0);
    check("abort_dz", 64'(div_by_zero), 64'd0);
    count_pulses(40, pulses);
    $display("op 1000/3 aborted: pulses after reset=%0d", pulses);
    check("abort_pulses", 64'(pulses), 64'd0);
    issue(32'd9, 32'd3, 1'b0);
    wait_result(lat);
    $display("op 9/3: q=%0d r=%0d", quotient, remainder);
    check("q_9_3", 64'(quotient), 64'd3);
    check("r_9_3", 64'(remainder), 64'd0);
    @(negedge clk);

`ifdef DIV_SIGNED_EN
    issue(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_result(lat);
    $display("op -7/2 signed: latency=%0d q=0x%0h r=0x%0h", lat, quotient, remainder);
    check("lat_s_m7_2", 64'(lat), 64'd33);
    check("q_s_m7_2", 64'(quotient), 64'hFFFF_FFFD);
    check("r_s_m7_2", 64'(remainder), 64'hFFFF_FFFF);
    @(negedge clk);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_result(lat);
    $display("op MIN/-1 signed: q=0x%0h r=0x%0h dz=%0d", quotient, remainder, div_by_zero);
    check("q_s_ovf", 64'(quotient), 64'h8000_0000);
    check("r_s_ovf", 64'(remainder), 64'd0);
    check("dz_s_ovf", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    issue(32'hFFFF_FFF7, 32'd0, 1'b1);
    wait_result(lat);
    $display("op -9/0 signed: q=0x%0h r=0x%0h dz=%0d", quotient, remainder, div_by_zero);
    check("q_s_dz", 64'(quotient), 64'hFFFF_FFFF);
    check("r_s_dz", 64'(remainder), 64'hFFFF_FFF7);
    check("dz_s_dz", 64'(div_by_zero), 64'd1);
    @(negedge clk);
`endif

    // Randomized traffic: starts at arbitrary times (including while busy
    // and during the out_valid cycle), operands changing mid-operation,
    // and occasional resets.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 799) == 0);
      signed_op = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 9))
        0: divisor = '0;
        1, 2, 3: divisor = $urandom_range(1, 15);
        4: divisor = ALL_ONES;
        default: divisor = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: dividend = MIN_VAL;
        1: dividend = $urandom_range(0, 100);
        default: dividend = $urandom;
      endcase
      if (out_valid)
        $display("txn cycle=%0d q=0x%0h r=0x%0h dz=%0d", cyc, quotient, remainder, div_by_zero);
    end
    start = 1'b0;
    rst = 1'b0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
